// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode constants and fetch sequencing states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [1:0] {
    START,
    FETCH,
    EXECUTE,
    HALTED
  } fetch_state_t;

  function automatic logic is_halt(input logic [31:0] word);
    return word[31:26] == OP_HALT;
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC selection: jump, taken branch, or sequential. Purely combinational so
// it can be shared with the pipelined core.
module next_pc_logic (
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] branch_off;
  logic        unused_opcode;

  assign unused_opcode = ^instr[31:26];

  always_comb begin
    branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_off;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and sequencing: holds the PC, fetches over a variable-latency
// request/valid handshake and presents the captured instruction to the decoder.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock_in,
  input  logic        reset_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_valid_in,
  input  logic [31:0] imem_data_in,
  output logic [31:0] instr_out,
  output logic [5:0]  opcode_out,
  output logic        instr_valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  input  logic        branch_in,
  input  logic        jump_in,
  input  logic        zero_in,
  input  logic        step_done_in,
  output logic        halted_out
);

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  instr;
  logic [31:0]  next_pc;
  logic         req_q;
  logic         ivalid_q;
  logic         halted_q;

  assign pc_plus4 = pc + 32'd4;

  next_pc_logic u_next_pc (
    .pc_plus4 (pc_plus4),
    .instr    (instr),
    .branch   (branch_in),
    .jump     (jump_in),
    .zero     (zero_in),
    .next_pc  (next_pc)
  );

  // Flags are updated alongside the state so every handshake output is a flop.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state    <= START;
      pc       <= PC_INIT;
      instr    <= '0;
      req_q    <= 1'b0;
      ivalid_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        START: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          if (imem_valid_in) begin
            instr <= imem_data_in;
            req_q <= 1'b0;
            if (is_halt(imem_data_in)) begin
              state    <= HALTED;
              halted_q <= 1'b1;
            end else begin
              state    <= EXECUTE;
              ivalid_q <= 1'b1;
            end
          end
        end
        EXECUTE: begin
          if (step_done_in) begin
            pc       <= next_pc;
            state    <= FETCH;
            ivalid_q <= 1'b0;
            req_q    <= 1'b1;
          end
        end
        HALTED: begin
        end
        default: begin
          state    <= START;
          req_q    <= 1'b0;
          ivalid_q <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_out    = req_q;
  assign imem_addr_out   = pc;
  assign pc_out          = pc;
  assign pc_plus4_out    = pc_plus4;
  assign instr_out       = instr;
  assign opcode_out      = instr[31:26];
  assign instr_valid_out = ivalid_q;
  assign halted_out      = halted_q;

endmodule
